// File: rtl/fetch_predict_unit.sv
// Fetch stage: sequential PC generator with a bimodal (2-bit counter) branch
// predictor and a small fetch queue that presents instructions to decode.
module fetch_predict_unit #(
  parameter int BHT_INDEX_BITS = 6,
  parameter int QUEUE_LOG      = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rob_redirect_valid,
  input  logic [31:0] rob_redirect_pc,
  input  logic        dec_redirect_valid,
  input  logic [31:0] dec_redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic [31:0] icache_req_pc,
  input  logic [31:0] icache_inst,
  input  logic        icache_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        pred_taken_out
);
  localparam int BHT_ENTRIES = 1 << BHT_INDEX_BITS;
  localparam int QDEPTH      = 1 << QUEUE_LOG;

  logic [31:0]          r_fetch_pc;
  logic [1:0]           r_bht    [BHT_ENTRIES];
  logic [31:0]          r_q_pc   [QDEPTH];
  logic [31:0]          r_q_inst [QDEPTH];
  logic                 r_q_pred [QDEPTH];
  logic [QUEUE_LOG-1:0] r_head;
  logic [QUEUE_LOG-1:0] r_tail;
  logic [QUEUE_LOG:0]   r_count;

  logic                      w_redirect;
  logic                      w_full;
  logic                      w_enq;
  logic                      w_deq;
  logic                      w_pred;
  logic [BHT_INDEX_BITS-1:0] w_lookup_idx;
  logic [BHT_INDEX_BITS-1:0] w_upd_idx;
  logic [1:0]                w_upd_cnt;
  logic [1:0]                w_upd_next;
  logic                      w_unused_upd_bits;

  assign w_redirect   = rob_redirect_valid | dec_redirect_valid;
  // count can only reach QDEPTH, so its MSB alone marks a full queue
  assign w_full       = r_count[QUEUE_LOG];
  assign w_enq        = icache_valid & ~w_full & ~w_redirect;
  assign w_deq        = out_valid & out_ready;
  assign w_lookup_idx = r_fetch_pc[BHT_INDEX_BITS+1:2];
  assign w_pred       = r_bht[w_lookup_idx][1];
  assign w_upd_idx    = upd_pc[BHT_INDEX_BITS+1:2];
  assign w_upd_cnt    = r_bht[w_upd_idx];
  assign w_unused_upd_bits = ^{upd_pc[31:BHT_INDEX_BITS+2], upd_pc[1:0]};

  assign icache_req_pc  = r_fetch_pc;
  assign out_valid      = (r_count != {(QUEUE_LOG+1){1'b0}}) & ~w_redirect;
  assign inst_out       = r_q_inst[r_head];
  assign pc_out         = r_q_pc[r_head];
  assign pred_taken_out = r_q_pred[r_head];

  always_comb begin
    w_upd_next = w_upd_cnt;
    if (upd_taken) begin
      if (w_upd_cnt != 2'b11) begin
        w_upd_next = w_upd_cnt + 2'b01;
      end else begin
        w_upd_next = w_upd_cnt;
      end
    end else begin
      if (w_upd_cnt != 2'b00) begin
        w_upd_next = w_upd_cnt - 2'b01;
      end else begin
        w_upd_next = w_upd_cnt;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fetch_pc <= 32'h0000_0000;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (rob_redirect_valid) begin
      r_fetch_pc <= rob_redirect_pc;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (dec_redirect_valid) begin
      r_fetch_pc <= dec_redirect_pc;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      if (w_enq) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_tail     <= r_tail + QUEUE_LOG'(1);
      end
      if (w_deq) begin
        r_head <= r_head + QUEUE_LOG'(1);
      end
      r_count <= r_count + (QUEUE_LOG+1)'(w_enq) - (QUEUE_LOG+1)'(w_deq);
    end
  end

  // payload storage needs no reset: out_valid masks stale slots
  always_ff @(posedge clk_in) begin
    if (w_enq && !rst_in) begin
      r_q_pc[r_tail]   <= r_fetch_pc;
      r_q_inst[r_tail] <= icache_inst;
      r_q_pred[r_tail] <= w_pred;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      r_bht[w_upd_idx] <= w_upd_next;
    end
  end
endmodule

// File: tb/tb_fetch_predict_unit.sv
// Directed bench for fetch_predict_unit: stimulus pushes expected queue
// outputs into a scoreboard that a negedge monitor drains.
module tb_fetch_predict_unit;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rob_redirect_valid = 1'b0;
  logic [31:0] rob_redirect_pc = 32'h0;
  logic        dec_redirect_valid = 1'b0;
  logic [31:0] dec_redirect_pc = 32'h0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_taken = 1'b0;
  logic [31:0] icache_req_pc;
  logic [31:0] icache_inst = 32'h0;
  logic        icache_valid = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        pred_taken_out;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_bad    = 0;

  fetch_predict_unit dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .rob_redirect_valid(rob_redirect_valid), .rob_redirect_pc(rob_redirect_pc),
    .dec_redirect_valid(dec_redirect_valid), .dec_redirect_pc(dec_redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .icache_req_pc(icache_req_pc), .icache_inst(icache_inst),
    .icache_valid(icache_valid), .out_valid(out_valid), .out_ready(out_ready),
    .inst_out(inst_out), .pc_out(pc_out), .pred_taken_out(pred_taken_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change only just after a rising edge; the monitor samples on the falling edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic pred);
    exp_t e;
    e.pc = pc; e.inst = inst; e.pred = pred;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    icache_valid = 1'b0; upd_valid = 1'b0;
    rob_redirect_valid = 1'b0; dec_redirect_valid = 1'b0;
    step();
    rst_in = 1'b0;
    sb.delete();
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken;
    step();
    upd_valid = 1'b0;
  endtask

  // Jump to pc via decoder redirect, fetch one instruction, drain it.
  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] inst, input logic pred);
    out_ready = 1'b1;
    dec_redirect_valid = 1'b1; dec_redirect_pc = pc;
    step();
    dec_redirect_valid = 1'b0;
    icache_valid = 1'b1; icache_inst = inst;
    push(pc, inst, pred);
    step();
    icache_valid = 1'b0;
    step();
    step();
  endtask

  always @(negedge clk_in) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_bad++;
        $display("FAIL unexpected_out: got pc=%h inst=%h, expected no output", pc_out, inst_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_pc", pc_out, e.pc);
        chk("out_inst", inst_out, e.inst);
        chk("out_pred", {31'h0, pred_taken_out}, {31'h0, e.pred});
      end
    end
  end

  initial begin
    // reset state
    step();
    step();
    rst_in = 1'b0;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_req_pc", icache_req_pc, 32'h0);

    // streaming A,B,C with consumer ready
    out_ready = 1'b1;
    icache_valid = 1'b1; icache_inst = 32'hAAAA_0001; push(32'h0, 32'hAAAA_0001, 1'b0);
    step();
    chk("lat_a", {31'h0, out_valid}, 32'h1);
    icache_inst = 32'hBBBB_0002; push(32'h4, 32'hBBBB_0002, 1'b0);
    step();
    chk("lat_b", {31'h0, out_valid}, 32'h1);
    icache_inst = 32'hCCCC_0003; push(32'h8, 32'hCCCC_0003, 1'b0);
    step();
    chk("lat_c", {31'h0, out_valid}, 32'h1);
    icache_valid = 1'b0;
    step();
    chk("drained", {31'h0, out_valid}, 32'h0);
    chk("pc_after_abc", icache_req_pc, 32'hC);

    // fill to capacity, then full-with-dequeue cycle must not enqueue
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      icache_valid = 1'b1; icache_inst = 32'h1000 + 32'(i);
      if (i < 8) push(32'(4 * i), 32'h1000 + 32'(i), 1'b0);
      step();
    end
    chk("full_stall_pc", icache_req_pc, 32'h20);
    chk("full_out_valid", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1; icache_inst = 32'h1111;
    step();
    chk("full_deq_no_enq_pc", icache_req_pc, 32'h20);
    icache_inst = 32'h2000; push(32'h20, 32'h2000, 1'b0);
    step();
    chk("enq_resume_pc", icache_req_pc, 32'h24);
    icache_valid = 1'b0;
    repeat (10) step();

    // simultaneous ROB and decoder redirect flush, BHT update still applied
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      icache_valid = 1'b1; icache_inst = 32'h3000 + 32'(i);
      push(32'(4 * i), 32'h3000 + 32'(i), 1'b0);
      step();
    end
    rob_redirect_valid = 1'b1; rob_redirect_pc = 32'h100;
    dec_redirect_valid = 1'b1; dec_redirect_pc = 32'h200;
    upd_valid = 1'b1; upd_pc = 32'h8; upd_taken = 1'b1;
    #1;
    chk("redir_out_valid", {31'h0, out_valid}, 32'h0);
    step();
    rob_redirect_valid = 1'b0; dec_redirect_valid = 1'b0; upd_valid = 1'b0;
    icache_valid = 1'b0;
    sb.delete();
    #1;
    chk("flush_empty", {31'h0, out_valid}, 32'h0);
    chk("redir_pc", icache_req_pc, 32'h100);
    out_ready = 1'b1;
    step();
    step();
    fetch_one(32'h8, 32'h4444_0008, 1'b1);

    // saturating counter training and aliasing
    do_reset();
    upd(32'h40, 1'b1);
    upd(32'h40, 1'b1);
    upd(32'h40, 1'b1);
    fetch_one(32'h40, 32'h5000_0040, 1'b1);
    fetch_one(32'h140, 32'h5000_0140, 1'b1);
    upd(32'h40, 1'b0);
    fetch_one(32'h40, 32'h5100_0040, 1'b1);
    upd(32'h40, 1'b0);
    upd(32'h40, 1'b0);
    upd(32'h40, 1'b0);
    fetch_one(32'h40, 32'h5200_0040, 1'b0);
    upd(32'h40, 1'b1);
    fetch_one(32'h40, 32'h5300_0040, 1'b0);

    // same-cycle update and lookup sees the pre-update counter
    do_reset();
    out_ready = 1'b1;
    dec_redirect_valid = 1'b1; dec_redirect_pc = 32'h40;
    step();
    dec_redirect_valid = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
    icache_valid = 1'b1; icache_inst = 32'h6000_0040; push(32'h40, 32'h6000_0040, 1'b0);
    step();
    upd_valid = 1'b0; icache_valid = 1'b0;
    step();
    step();
    fetch_one(32'h40, 32'h6100_0040, 1'b1);

    // reset mid-operation discards queued entries
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      icache_valid = 1'b1; icache_inst = 32'h7000 + 32'(i);
      push(32'(4 * i), 32'h7000 + 32'(i), 1'b0);
      step();
    end
    rst_in = 1'b1;
    step();
    rst_in = 1'b0; icache_valid = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_pc", icache_req_pc, 32'h0);
    out_ready = 1'b1;
    step();
    step();
    fetch_one(32'h0, 32'h7777_0000, 1'b0);

    repeat (4) step();
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
